// File: rtl/stopwatch_pkg.sv
// Shared types and limits for the stopwatch core.
// Digit width, per-pair limits and the run-state encoding.
package stopwatch_pkg;

    localparam int DIGIT_W   = 4;
    localparam int CENTI_MAX = 99;
    localparam int SEC_MAX   = 59;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_digit_pair.sv
// Two-digit BCD counter with parameterised modulus.
// o_next is the value after this edge so callers can snapshot it.
module bcd_digit_pair
    import stopwatch_pkg::*;
#(
    parameter int MODULUS = 100
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_inc,
    input  logic                   i_clr,
    output logic [2*DIGIT_W-1:0]   o_next,
    output logic                   o_carry
);

    localparam int MAX_VAL = MODULUS - 1;
    localparam logic [DIGIT_W-1:0] MAX_T = DIGIT_W'(MAX_VAL / 10);
    localparam logic [DIGIT_W-1:0] MAX_U = DIGIT_W'(MAX_VAL % 10);

    logic [2*DIGIT_W-1:0] r_q;
    logic [2*DIGIT_W-1:0] w_d;
    logic                 w_at_max;

    assign w_at_max = (r_q == {MAX_T, MAX_U});
    assign o_carry  = i_inc & w_at_max & ~i_clr;
    assign o_next   = w_d;

    always_comb begin
        w_d = r_q;
        if (i_clr) begin
            w_d = '0;
        end else if (i_inc) begin
            if (w_at_max) begin
                w_d = '0;
            end else if (r_q[DIGIT_W-1:0] == DIGIT_W'(9)) begin
                w_d = {r_q[2*DIGIT_W-1:DIGIT_W] + DIGIT_W'(1), {DIGIT_W{1'b0}}};
            end else begin
                w_d = {r_q[2*DIGIT_W-1:DIGIT_W], r_q[DIGIT_W-1:0] + DIGIT_W'(1)};
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= '0;
        end else begin
            r_q <= w_d;
        end
    end

endmodule

// File: rtl/stopwatch_core.sv
// Centisecond stopwatch: run/pause FSM, BCD mm:ss.cc chain, lap freeze.
// All outputs are registered from next-state values of the live chain.
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int MIN_MODULUS = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        start_stop,
    input  logic        lap,
    input  logic        clear,
    output logic [23:0] disp,
    output logic        running,
    output logic        lap_hold,
    output logic        wrap
);

    state_t      r_state;
    state_t      w_next_state;
    logic        w_clr;
    logic        w_inc;
    logic        w_lap_cap;
    logic        w_hold_next;
    logic        w_c_carry;
    logic        w_s_carry;
    logic        w_m_carry;
    logic [7:0]  w_centi;
    logic [7:0]  w_sec;
    logic [7:0]  w_min;
    logic [23:0] w_live_next;
    logic [23:0] w_lap_next;
    logic [23:0] r_lap;
    logic [23:0] r_disp;
    logic        r_hold;
    logic        r_running;
    logic        r_wrap;

    assign w_inc = tick & (r_state == S_RUN);

    always_comb begin
        w_next_state = r_state;
        w_clr        = 1'b0;
        w_lap_cap    = 1'b0;
        w_hold_next  = r_hold;
        // clear is only honoured when stopped; otherwise lower commands proceed
        if (clear && (r_state != S_RUN)) begin
            w_clr        = 1'b1;
            w_next_state = S_IDLE;
            w_hold_next  = 1'b0;
        end else if (start_stop) begin
            unique case (r_state)
                S_IDLE:  w_next_state = S_RUN;
                S_RUN:   w_next_state = S_PAUSE;
                S_PAUSE: w_next_state = S_RUN;
                default: w_next_state = S_IDLE;
            endcase
        end else if (lap) begin
            if ((r_state == S_RUN) && !r_hold) begin
                w_lap_cap   = 1'b1;
                w_hold_next = 1'b1;
            end else if ((r_state != S_IDLE) && r_hold) begin
                w_hold_next = 1'b0;
            end
        end
    end

    bcd_digit_pair #(.MODULUS(CENTI_MAX + 1)) u_centi (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_inc   (w_inc),
        .i_clr   (w_clr),
        .o_next  (w_centi),
        .o_carry (w_c_carry)
    );

    bcd_digit_pair #(.MODULUS(SEC_MAX + 1)) u_sec (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_inc   (w_c_carry),
        .i_clr   (w_clr),
        .o_next  (w_sec),
        .o_carry (w_s_carry)
    );

    bcd_digit_pair #(.MODULUS(MIN_MODULUS)) u_min (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_inc   (w_s_carry),
        .i_clr   (w_clr),
        .o_next  (w_min),
        .o_carry (w_m_carry)
    );

    assign w_live_next = {w_min, w_sec, w_centi};
    assign w_lap_next  = w_lap_cap ? w_live_next : r_lap;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_lap     <= '0;
            r_disp    <= '0;
            r_hold    <= 1'b0;
            r_running <= 1'b0;
            r_wrap    <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_lap     <= w_lap_next;
            r_disp    <= w_hold_next ? w_lap_next : w_live_next;
            r_hold    <= w_hold_next;
            r_running <= (w_next_state == S_RUN);
            r_wrap    <= w_m_carry;
        end
    end

    assign disp     = r_disp;
    assign running  = r_running;
    assign lap_hold = r_hold;
    assign wrap     = r_wrap;

endmodule

// File: doc/stopwatch_core.md
STOPWATCH_CORE -- requirements
Module: stopwatch_core

Interface
REQ-001 The module SHALL have parameter MIN_MODULUS, default 60, giving the minutes wrap modulus (2..99).
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: the reset, asynchronous and active-low.
REQ-004 The module SHALL have port tick, input, 1 bit: a one-cycle pulse at 100 Hz from the upstream tick timer, one count per centisecond.
REQ-005 The module SHALL have port start_stop, input, 1 bit: a one-cycle command pulse that toggles run/pause.
REQ-006 The module SHALL have port lap, input, 1 bit: a one-cycle command pulse that toggles the frozen lap display.
REQ-007 The module SHALL have port clear, input, 1 bit: a one-cycle command pulse that zeroes the time.
REQ-008 The module SHALL have port disp, output, 24 bits: BCD mm:ss.cc with bits [23:20]=min tens down to [3:0]=centi units.
REQ-009 The module SHALL have port running, output, 1 bit: high while in RUN.
REQ-010 The module SHALL have port lap_hold, output, 1 bit: high while disp shows the frozen lap value.
REQ-011 The module SHALL have port wrap, output, 1 bit: a one-cycle pulse when the time rolls over to 00:00.00.

Function
REQ-012 The FSM SHALL have states IDLE, RUN and PAUSE.
REQ-013 The FSM SHALL move IDLE->RUN, RUN->PAUSE and PAUSE->RUN on start_stop.
REQ-014 In PAUSE or IDLE, clear SHALL zero the live time and lap_hold and move the FSM to IDLE; clear in RUN SHALL be ignored.
REQ-015 Command priority within one cycle SHALL be clear > start_stop > lap.
REQ-016 A tick SHALL be counted only when the state before the edge is RUN; tick together with start_stop in RUN SHALL be counted, and in IDLE or PAUSE SHALL not.
REQ-017 The counter chain SHALL be centi 00-99, then sec 00-59, then min 00-(MIN_MODULUS-1), each digit pure BCD; a carry SHALL ripple within the same cycle.
REQ-018 A tick at the maximum value (e.g. 59:59.99) SHALL wrap the time to 00:00.00 and assert wrap in the next cycle for exactly one cycle.
REQ-019 disp, running and wrap SHALL be registered: disp SHALL reflect a counted tick exactly one cycle after the tick.
REQ-020 A lap while lap_hold=0 in RUN SHALL capture the live time (including any tick counted in that cycle) into the lap register and set lap_hold.
REQ-021 A lap while lap_hold=1 in RUN or PAUSE SHALL clear lap_hold; a lap in IDLE, or a lap in PAUSE with lap_hold=0, SHALL be ignored.
REQ-022 While lap_hold=1, disp SHALL show the lap register and the live time SHALL keep counting; otherwise disp SHALL show the live time.
REQ-023 Live time SHALL be retained in PAUSE.

Reset
REQ-024 Asserting rst low SHALL immediately force state=IDLE, live time=0, lap register=0, disp=24'h0, running=0, lap_hold=0 and wrap=0, independently of clk.
REQ-025 Reset mid-RUN SHALL discard all counts; the first command after release SHALL be handled as from IDLE.

Structure
REQ-026 The package stopwatch_pkg SHALL hold the state enum, BCD digit width (4), and the limits 99 (centi) and 59 (sec).
REQ-027 One sub-module, bcd_digit_pair, SHALL implement a two-digit BCD counter with parameterised modulus, an increment enable, synchronous clear and a carry-out, instantiated three times.

Verification
REQ-028 The bench SHALL cover: reset, start_stop, 150 ticks -> disp=24'h000150, running=1.
REQ-029 The bench SHALL cover: live 00:59.99 in RUN, one tick -> disp=24'h010000 one cycle later, with no wrap.
REQ-030 The bench SHALL cover: live 59:59.99 in RUN, one tick -> disp=24'h000000 and a one-cycle wrap pulse.
REQ-031 The bench SHALL cover: RUN at 00:00.05, lap, then 20 ticks -> disp holds 24'h000005; a second lap -> disp=24'h000025.
REQ-032 The bench SHALL cover: RUN, start_stop with simultaneous tick -> count incremented by 1 and state PAUSE; further ticks ignored; clear -> disp=0 and state IDLE.
REQ-033 The bench SHALL cover: clear asserted in RUN -> ignored; rst pulsed low mid-RUN -> all outputs 0 asynchronously.
